// File: rtl/mic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mic_pkg                                                   |
// | Desc     : Shared mic clock constants and FSM state encoding         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package mic_pkg;

    localparam int c_def_period = 40;
    localparam int c_div_min    = 4;

    typedef logic [1:0] mic_state_t;

    localparam mic_state_t c_st_idle = 2'd0;
    localparam mic_state_t c_st_run  = 2'd1;
    localparam mic_state_t c_st_stop = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mic_period_shadow.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mic_period_shadow                                         |
// | Desc     : Clamped period shadow register, pending flag and ack      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module mic_period_shadow
    import mic_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = c_def_period,
    parameter int DIV_MIN    = c_div_min
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_freeze,
    input  logic             i_cfg_wr,
    input  logic [CNT_W-1:0] i_cfg_period,
    input  logic             i_apply_req,
    output logic             o_apply,
    output logic [CNT_W-1:0] o_shadow,
    output logic             o_cfg_ack
);

    localparam logic [CNT_W-1:0] c_min = CNT_W'(DIV_MIN);

    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_ack;
    logic [CNT_W-1:0] w_clamped;

    assign w_clamped = (i_cfg_period < c_min) ? c_min : i_cfg_period;
    // The apply uses the shadow as it stood before any write in this cycle.
    assign o_apply   = i_apply_req & r_pending & ~i_freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow  <= CNT_W'(DEF_PERIOD);
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
        end else if (i_freeze) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= o_apply;
            if (i_cfg_wr) begin
                r_shadow <= w_clamped;
            end
            r_pending <= i_cfg_wr | (r_pending & ~o_apply);
        end
    end

    assign o_shadow  = r_shadow;
    assign o_cfg_ack = r_ack;

endmodule
`default_nettype wire

// File: rtl/mic_hclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mic_hclk_gen                                              |
// | Desc     : Programmable mic bit clock generator with edge strobes    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module mic_hclk_gen
    import mic_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = c_def_period,
    parameter int DIV_MIN    = c_div_min
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             speed_md,
    input  logic             en,
    input  logic             cfg_wr,
    input  logic [CNT_W-1:0] cfg_period,
    output logic             cfg_ack,
    output logic             mic_clk,
    output logic             mic_clk_pos,
    output logic             mic_clk_neg,
    output logic             busy,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    mic_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_per_a;
    logic [CNT_W-1:0] r_edge_cnt, w_edge_nxt;
    logic             r_mic_clk, w_mic_clk_nxt;
    logic             r_pos, w_pos_nxt;
    logic             r_neg, w_neg_nxt;
    logic [CNT_W-1:0] w_high_a, w_cnt_inc, w_last;
    logic             w_boundary, w_apply_req, w_apply;
    logic [CNT_W-1:0] w_shadow;

    assign w_high_a   = r_per_a >> 1;
    assign w_cnt_inc  = r_cnt + c_one;
    assign w_last     = r_per_a - c_one;
    assign w_boundary = (r_cnt == w_last);

    mic_period_shadow #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD),
        .DIV_MIN    (DIV_MIN)
    ) u_shadow (
        .clk          (clk),
        .rst          (rst),
        .i_freeze     (speed_md),
        .i_cfg_wr     (cfg_wr),
        .i_cfg_period (cfg_period),
        .i_apply_req  (w_apply_req),
        .o_apply      (w_apply),
        .o_shadow     (w_shadow),
        .o_cfg_ack    (cfg_ack)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_mic_clk_nxt = r_mic_clk;
        w_edge_nxt    = r_edge_cnt;
        w_pos_nxt     = 1'b0;
        w_neg_nxt     = 1'b0;
        w_apply_req   = 1'b0;
        if (!speed_md) begin
            case (r_state)
                c_st_idle: begin
                    w_apply_req   = 1'b1;
                    w_cnt_nxt     = '0;
                    w_mic_clk_nxt = 1'b0;
                    if (en) begin
                        w_state_nxt   = c_st_run;
                        w_mic_clk_nxt = 1'b1;
                        w_pos_nxt     = 1'b1;
                        w_edge_nxt    = c_one;
                    end
                end
                c_st_run, c_st_stop: begin
                    if (w_boundary) begin
                        w_cnt_nxt   = '0;
                        w_apply_req = 1'b1;
                        // A stop request only takes effect once the period has run out.
                        if (en) begin
                            w_state_nxt   = c_st_run;
                            w_mic_clk_nxt = 1'b1;
                            w_pos_nxt     = 1'b1;
                            w_edge_nxt    = r_edge_cnt + c_one;
                        end else begin
                            w_state_nxt = c_st_idle;
                        end
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                        w_state_nxt = en ? c_st_run : c_st_stop;
                        if (w_cnt_inc == w_high_a) begin
                            w_mic_clk_nxt = 1'b0;
                            w_neg_nxt     = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt   = c_st_idle;
                    w_cnt_nxt     = '0;
                    w_mic_clk_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_per_a    <= CNT_W'(DEF_PERIOD);
            r_edge_cnt <= '0;
            r_mic_clk  <= 1'b0;
            r_pos      <= 1'b0;
            r_neg      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_edge_cnt <= w_edge_nxt;
            r_mic_clk  <= w_mic_clk_nxt;
            r_pos      <= w_pos_nxt;
            r_neg      <= w_neg_nxt;
            if (w_apply) begin
                r_per_a <= w_shadow;
            end
        end
    end

    assign mic_clk     = r_mic_clk;
    assign mic_clk_pos = r_pos;
    assign mic_clk_neg = r_neg;
    assign busy        = (r_state != c_st_idle);
    assign edge_cnt    = r_edge_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mic_hclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mic_hclk_gen                                           |
// | Desc     : Randomized bench against a phase-based reference model    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_mic_hclk_gen;

    logic        clk = 1'b0;
    logic        rst, speed_md, en, cfg_wr;
    logic [15:0] cfg_period;
    logic        cfg_ack, mic_clk, mic_clk_pos, mic_clk_neg, busy;
    logic [15:0] edge_cnt;

    logic        wrap_en;
    logic        wrap_ack, wrap_clk, wrap_pos, wrap_neg, wrap_busy;
    logic [5:0]  wrap_edge;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    mic_hclk_gen u_dut (
        .clk         (clk),
        .rst         (rst),
        .speed_md    (speed_md),
        .en          (en),
        .cfg_wr      (cfg_wr),
        .cfg_period  (cfg_period),
        .cfg_ack     (cfg_ack),
        .mic_clk     (mic_clk),
        .mic_clk_pos (mic_clk_pos),
        .mic_clk_neg (mic_clk_neg),
        .busy        (busy),
        .edge_cnt    (edge_cnt)
    );

    mic_hclk_gen #(.CNT_W(6), .DEF_PERIOD(4), .DIV_MIN(4)) u_wrap (
        .clk         (clk),
        .rst         (rst),
        .speed_md    (1'b0),
        .en          (wrap_en),
        .cfg_wr      (1'b0),
        .cfg_period  (6'd0),
        .cfg_ack     (wrap_ack),
        .mic_clk     (wrap_clk),
        .mic_clk_pos (wrap_pos),
        .mic_clk_neg (wrap_neg),
        .busy        (wrap_busy),
        .edge_cnt    (wrap_edge)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Model: the mic clock is a function of the phase within the current period.
    int m_act, m_ph, m_per, m_shadow, m_pend, m_edges;
    bit m_clk, e_pos, e_neg, e_ack;

    function automatic void model_step();
        bit at_end, take, prev;
        int nper;
        if (rst) begin
            m_act = 0; m_ph = 0; m_per = 40; m_shadow = 40; m_pend = 0; m_edges = 0;
            m_clk = 0; e_pos = 0; e_neg = 0; e_ack = 0;
            return;
        end
        if (speed_md) begin
            e_pos = 0; e_neg = 0; e_ack = 0;
            return;
        end
        at_end = (m_act != 0) && (m_ph == m_per - 1);
        take   = (m_pend != 0) && ((m_act == 0) || at_end);
        nper   = take ? m_shadow : m_per;
        e_ack  = take;
        if (cfg_wr) begin
            m_shadow = (int'(cfg_period) < 4) ? 4 : int'(cfg_period);
            m_pend   = 1;
        end else if (take) begin
            m_pend = 0;
        end
        prev = m_clk;
        if ((m_act == 0) || at_end) begin
            if (en) begin
                m_edges = (m_act == 0) ? 1 : (m_edges + 1) % 65536;
                m_act   = 1;
                m_ph    = 0;
            end else begin
                m_act = 0;
            end
        end else begin
            m_ph++;
        end
        m_per = nper;
        m_clk = (m_act != 0) && (m_ph < m_per / 2);
        e_pos = m_clk && !prev;
        e_neg = !m_clk && prev;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        chk("mic_clk", mic_clk, m_clk);
        chk("pos", mic_clk_pos, e_pos);
        chk("neg", mic_clk_neg, e_neg);
        chk("ack", cfg_ack, e_ack);
        chk("busy", busy, m_act != 0);
        chk("edge_cnt", edge_cnt, m_edges);
    endtask

    task automatic write_cfg(input int val);
        cfg_wr     = 1'b1;
        cfg_period = 16'(val);
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic wait_model(input bit want_end, input int ph);
        int k;
        for (k = 0; k < 200; k++) begin
            if (m_act != 0 && (want_end ? (m_ph == m_per - 1) : (m_ph == ph))) break;
            tick();
        end
        if (k == 200) chk("wait_timeout", 0, 1);
    endtask

    initial begin
        int acks, t0, t1, burst;
        rst = 1'b1; speed_md = 1'b0; en = 1'b0; cfg_wr = 1'b0; cfg_period = '0; wrap_en = 1'b0;
        repeat (3) tick();
        chk("rst_clk", mic_clk, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        en = 1'b1;
        tick();
        chk("first_pos", mic_clk_pos, 1);
        repeat (99) tick();

        write_cfg(7);
        repeat (60) tick();
        write_cfg(2);
        repeat (30) tick();

        wait_model(1'b0, 1);
        en = 1'b0;
        repeat (20) tick();
        chk("stop_busy", busy, 0);
        chk("stop_clk", mic_clk, 0);
        en = 1'b1;
        repeat (6) tick();
        en = 1'b0;
        tick();
        en = 1'b1;
        repeat (20) tick();

        write_cfg(40);
        repeat (50) tick();
        speed_md = 1'b1;
        repeat (10) tick();
        speed_md = 1'b0;
        repeat (90) tick();

        wait_model(1'b1, 0);
        write_cfg(12);
        acks = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            acks += int'(cfg_ack);
        end
        chk("one_ack", acks, 1);

        write_cfg(25);
        repeat (60) tick();
        t0 = -1; t1 = -1;
        for (int i = 0; i < 200 && t1 < 0; i++) begin
            tick();
            if (mic_clk_pos) begin
                if (t0 < 0) t0 = cyc; else t1 = cyc;
            end
        end
        chk("meas_25", t1 - t0 - 1, 24);

        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(39, 0) == 0) en = ~en;
            cfg_wr = 1'b0;
            if ($urandom_range(49, 0) == 0 || (m_act != 0 && m_ph == m_per - 1 && $urandom_range(3, 0) == 0)) begin
                cfg_wr     = 1'b1;
                cfg_period = 16'($urandom_range(30, 0));
            end
            if (burst > 0) burst--;
            else if ($urandom_range(99, 0) == 0) burst = $urandom_range(12, 1);
            speed_md = (burst > 0);
            rst      = ($urandom_range(1499, 0) == 0);
            tick();
        end
        rst = 1'b0; speed_md = 1'b0; cfg_wr = 1'b0; en = 1'b0;
        repeat (60) tick();

        wrap_en = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            chk("wrap_pos", wrap_pos, ((k - 1) % 4) == 0);
            chk("wrap_edge", wrap_edge, ((k - 1) / 4 + 1) % 64);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
